// File: rtl/piso_shift_register_if.sv
// Stream bundle for the parallel-in/serial-out shifter: parallel word in, one element per cycle out.
interface piso_shift_register_if #(
    parameter int unsigned data_width = 16,
    parameter int unsigned size       = 3
);
    localparam int unsigned WORD_W = data_width * size;

    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_W-1:0]     data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [data_width-1:0] data_out;
    logic                  out_last;
    logic                  busy;

    // Producer of words / consumer of elements
    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, out_last, busy
    );

    // The shifter itself
    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, out_last, busy
    );
endinterface

// File: rtl/piso_shift_register.sv
// Parallel-in/serial-out shifter: loads a packed word, emits its elements lowest slice first on a
// valid/ready stream, with a back-to-back reload in the cycle the last element leaves.
module piso_shift_register #(
    parameter int unsigned data_width = 16,
    parameter int unsigned size       = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    piso_shift_register_if.slave   bus
);
    localparam int unsigned WORD_W = data_width * size;
    localparam int unsigned CNT_W  = (size > 1) ? $clog2(size) : 1;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WORD_W-1:0]  buffer, buffer_n;
    logic               last;
    logic               emit;
    logic               accept;
    logic               in_ready_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            buffer <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            buffer <= buffer_n;
        end
    end

    // Current element always sits in the low slice; ce=0 blocks both handshakes so everything holds
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        buffer_n   = buffer;
        last       = (state == SHIFT) && (cnt == CNT_W'(size - 1));
        emit       = ce && (state == SHIFT) && bus.out_ready;
        in_ready_c = ce && ((state == IDLE) || (last && bus.out_ready));
        accept     = in_ready_c && bus.in_valid;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    buffer_n = bus.data_in;
                    cnt_n    = '0;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                if (emit) begin
                    if (!last) begin
                        buffer_n = buffer >> data_width;
                        cnt_n    = cnt + CNT_W'(1);
                    end else if (accept) begin
                        buffer_n = bus.data_in;
                        cnt_n    = '0;
                    end else begin
                        state_n  = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state == SHIFT);
    assign bus.busy      = (state == SHIFT);
    assign bus.out_last  = last;
    assign bus.data_out  = buffer[data_width-1:0];

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: cycle table of expected outputs plus a scoreboard of emitted elements.
module tb_piso_shift_register;
    localparam int unsigned DW     = 16;
    localparam int unsigned SZ     = 3;
    localparam int unsigned WORD_W = DW * SZ;

    typedef struct {
        logic              ce;
        logic              iv;
        logic [WORD_W-1:0] d;
        logic              ordy;
        logic              ev;
        logic [DW-1:0]     ed;
        logic              el;
        logic              er;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } elem_t;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    int   n_vec = 0;
    int   n_mis = 0;
    vec_t  vecs[$];
    elem_t sb[$];

    piso_shift_register_if #(.data_width(DW), .size(SZ)) bus ();

    piso_shift_register #(.data_width(DW), .size(SZ)) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then score handshakes before the rising edge
    task automatic drive(input logic c, input logic iv, input logic [WORD_W-1:0] d, input logic o);
        elem_t e;
        @(negedge clk);
        ce            = c;
        bus.in_valid  = iv;
        bus.data_in   = d;
        bus.out_ready = o;
        #1;
        if (c && iv && bus.in_ready) begin
            for (int k = 0; k < SZ; k++) begin
                e.data = d[k*DW +: DW];
                e.last = (k == SZ - 1);
                sb.push_back(e);
            end
        end
        if (c && bus.out_valid && o) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("sb_data", 64'(bus.data_out), 64'(e.data));
                check("sb_last", 64'(bus.out_last), 64'(e.last));
            end
        end
    endtask

    task automatic add(input logic c, input logic iv, input logic [WORD_W-1:0] d, input logic o,
                       input logic ev, input logic [DW-1:0] ed, input logic el, input logic er);
        vec_t v;
        v.ce = c; v.iv = iv; v.d = d; v.ordy = o;
        v.ev = ev; v.ed = ed; v.el = el; v.er = er;
        vecs.push_back(v);
    endtask

    initial begin
        logic [WORD_W-1:0] w1, w2, wa, wb, wc, wd, we;
        logic [WORD_W-1:0] junk;
        int budget;

        w1   = {16'h0003, 16'h0002, 16'h0001};
        w2   = {16'h0030, 16'h0020, 16'h0010};
        wa   = {16'h00A2, 16'h00A1, 16'h00A0};
        wb   = {16'h00B2, 16'h00B1, 16'h00B0};
        wc   = {16'h00C2, 16'h00C1, 16'h00C0};
        wd   = {16'h00D2, 16'h00D1, 16'h00D0};
        we   = {16'h00E2, 16'h00E1, 16'h00E0};
        junk = 48'hDEAD_BEEF_CAFE;

        //  ce  iv  data  ordy  exp: valid data     last ready
        add(1, 0, '0,   1,  0, 16'h0000, 0, 1);   // reset state
        add(1, 1, w1,   1,  0, 16'h0000, 0, 1);   // accept w1
        add(1, 0, '0,   1,  1, 16'h0001, 0, 0);
        add(1, 0, '0,   1,  1, 16'h0002, 0, 0);
        add(1, 0, '0,   1,  1, 16'h0003, 1, 1);
        add(1, 0, '0,   1,  0, 16'h0003, 0, 1);   // idle, data_out holds
        add(1, 1, w2,   1,  0, 16'h0003, 0, 1);   // accept w2
        add(1, 0, '0,   1,  1, 16'h0010, 0, 0);
        for (int i = 0; i < 4; i++)
            add(1, 0, '0, 0,  1, 16'h0020, 0, 0); // backpressure on element 2
        add(1, 0, '0,   1,  1, 16'h0020, 0, 0);
        add(1, 1, wa,   1,  1, 16'h0030, 1, 1);   // last of w2 + accept A
        add(1, 1, wb,   1,  1, 16'h00A0, 0, 0);
        add(1, 1, wb,   1,  1, 16'h00A1, 0, 0);
        add(1, 1, wb,   1,  1, 16'h00A2, 1, 1);   // last of A + accept B
        add(1, 0, '0,   1,  1, 16'h00B0, 0, 0);
        add(1, 0, '0,   1,  1, 16'h00B1, 0, 0);
        add(1, 0, '0,   1,  1, 16'h00B2, 1, 1);
        add(1, 0, '0,   1,  0, 16'h00B2, 0, 1);
        add(1, 1, wc,   1,  0, 16'h00B2, 0, 1);   // accept C
        add(1, 0, '0,   1,  1, 16'h00C0, 0, 0);
        add(0, 0, '0,   1,  1, 16'h00C1, 0, 0);   // ce gated
        add(0, 1, junk, 1,  1, 16'h00C1, 0, 0);
        add(1, 0, '0,   1,  1, 16'h00C1, 0, 0);
        add(1, 0, '0,   1,  1, 16'h00C2, 1, 1);
        add(1, 0, '0,   1,  0, 16'h00C2, 0, 1);

        rst           = 1'b1;
        ce            = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].ce, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            check($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].ev));
            check($sformatf("v%0d_busy", i),  64'(bus.busy),      64'(vecs[i].ev));
            check($sformatf("v%0d_data", i),  64'(bus.data_out),  64'(vecs[i].ed));
            check($sformatf("v%0d_last", i),  64'(bus.out_last),  64'(vecs[i].el));
            check($sformatf("v%0d_ready", i), 64'(bus.in_ready),  64'(vecs[i].er));
        end
        check("sb_empty_after_table", 64'(sb.size()), 64'(0));

        // Asynchronous reset mid-word, asserted between clock edges
        drive(1, 1, wd, 1);
        drive(1, 0, '0, 1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(bus.out_valid), 64'(0));
        check("arst_data",  64'(bus.data_out),  64'(0));
        check("arst_last",  64'(bus.out_last),  64'(0));
        check("arst_busy",  64'(bus.busy),      64'(0));
        sb.delete();
        @(negedge clk);
        rst = 1'b0;

        drive(1, 1, we, 1);
        check("post_rst_first", 64'(bus.out_valid), 64'(0));
        budget = 0;
        while (sb.size() != 0 && budget < 10) begin
            drive(1, 0, '0, 1);
            budget++;
        end
        check("post_rst_drain", 64'(sb.size()), 64'(0));
        check("post_rst_emits", 64'(budget), 64'(SZ));
        drive(1, 0, '0, 1);
        check("post_rst_idle_valid", 64'(bus.out_valid), 64'(0));
        check("post_rst_idle_data",  64'(bus.data_out),  64'(16'h00E2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
